// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Host-to-device PS/2 transmitter. Accepts one byte on a valid/ready
//   handshake, then runs the host request-to-send sequence: clock inhibit,
//   start bit, 8 data bits LSB first, odd parity, stop, and device ACK.
//   Both PS/2 lines are driven open-drain through *_oe (1 = pull low).
//
// Parameters
//   INHIBIT_CYCLES : cycles the clock line is held low to request-to-send (>= 2)
//   TIMEOUT_CYCLES : cycles allowed in START/BITS/ACK before aborting
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   tx_data, tx_valid     : byte to send and its request strobe
//   tx_ready              : high only while idle
//   ps2_clk_in/data_in    : raw asynchronous pad samples
//   ps2_clk_oe/data_oe    : open-drain pull-low enables
//   done                  : one-cycle pulse, byte sent and ACKed
//   error                 : one-cycle pulse, NACK or timeout
//
// Build option
//   PS2_TX_RETRY_EN : on NACK or timeout, re-send the latched byte once before
//                     reporting error.

module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error
);

  localparam int unsigned MAX_CYCLES =
    (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       frame_q;    // {stop, parity, data[7:0]}
  logic [3:0]       bit_cnt_q;
  logic             ack_ok_q;
  logic             tx_ready_q;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             done_q;
  logic             error_q;
`ifdef PS2_TX_RETRY_EN
  logic             retried_q;
`endif

  // Pad synchronizers; clk_prev_q is the edge-detect register.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic clk_fall_d;
  logic timeout_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall_d = clk_prev_q & ~clk_sync_q;
  assign timeout_d  = (state_q inside {S_START, S_BITS, S_ACK}) && (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      ack_ok_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried_q  <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (timeout_d) begin
        // Timeout overrides any edge seen in the same cycle.
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        cnt_q     <= '0;
`ifdef PS2_TX_RETRY_EN
        if (!retried_q) begin
          retried_q <= 1'b1;
          clk_oe_q  <= 1'b1;
          state_q   <= S_INHIBIT;
        end else begin
          error_q    <= 1'b1;
          tx_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
`else
        error_q    <= 1'b1;
        tx_ready_q <= 1'b1;
        state_q    <= S_IDLE;
`endif
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tx_valid) begin
              frame_q    <= {1'b1, ~^tx_data, tx_data};
              cnt_q      <= '0;
              clk_oe_q   <= 1'b1;
              tx_ready_q <= 1'b0;
              state_q    <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retried_q  <= 1'b0;
`endif
            end
          end
          S_INHIBIT: begin
            cnt_q <= cnt_q + 1'b1;
            // Data goes low one cycle before the clock is released.
            if (cnt_q == INH_DATA) data_oe_q <= 1'b1;
            if (cnt_q == INH_LAST) begin
              clk_oe_q <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_START;
            end
          end
          S_START: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall_d) begin
              data_oe_q <= ~frame_q[0];
              bit_cnt_q <= 4'd1;
              state_q   <= S_BITS;
            end
          end
          S_BITS: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall_d) begin
              data_oe_q <= ~frame_q[bit_cnt_q];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 4'd9) state_q <= S_ACK;
            end
          end
          S_ACK: begin
            cnt_q <= cnt_q + 1'b1;
            if (clk_fall_d) begin
              ack_ok_q <= ~data_sync_q;
              state_q  <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (clk_sync_q && data_sync_q) begin
              cnt_q <= '0;
              if (ack_ok_q) begin
                done_q     <= 1'b1;
                tx_ready_q <= 1'b1;
                state_q    <= S_IDLE;
              end else begin
`ifdef PS2_TX_RETRY_EN
                if (!retried_q) begin
                  retried_q <= 1'b1;
                  clk_oe_q  <= 1'b1;
                  state_q   <= S_INHIBIT;
                end else begin
                  error_q    <= 1'b1;
                  tx_ready_q <= 1'b1;
                  state_q    <= S_IDLE;
                end
`else
                error_q    <= 1'b1;
                tx_ready_q <= 1'b1;
                state_q    <= S_IDLE;
`endif
              end
            end
          end
          default: begin
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: doc/ps2_host_transmitter.md
# ps2_host_transmitter

Host-to-device PS/2 transmitter: accepts one byte over a valid/ready handshake and sends it to the keyboard using the PS/2 host-request protocol (clock inhibit, start, 8 data bits LSB first, odd parity, stop, device ACK). It sits beside `keyboard_controller` on the `clock` (50 MHz) domain and shares the same PS/2 pads via open-drain enables. Game logic uses it to send commands such as LED set (0xED) and reset (0xFF).

## Interface
- `INHIBIT_CYCLES`, 5000: cycles the clock line is held low to request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1000000: maximum cycles from clock release to ACK edge (20 ms).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  request; byte accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `ps2_clk_in`  in  1  raw PS/2 clock pad sample (asynchronous).
- `ps2_data_in`  in  1  raw PS/2 data pad sample (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull clock line low, 0 = release.
- `ps2_data_oe`  out  1  1 = pull data line low, 0 = release.
- `done`  out  1  one-cycle pulse: byte sent and ACKed.
- `error`  out  1  one-cycle pulse: NACK or timeout.

## Operation
- Both pad inputs pass through 2-flop synchronizers; falling edge of PS/2 clock = previous synced 1, current synced 0.
- Frame latched on acceptance: 8 data bits, parity = `~^tx_data` (odd), stop = 1.
- States: IDLE → INHIBIT → START → BITS → ACK → WAIT_IDLE → IDLE.
- IDLE: both oe = 0, `tx_ready` = 1. Acceptance → INHIBIT, counter cleared.
- INHIBIT: `ps2_clk_oe` = 1 for `INHIBIT_CYCLES`; `ps2_data_oe` asserted in the last cycle of INHIBIT. Then → START.
- START: `ps2_clk_oe` = 0, `ps2_data_oe` = 1 (start bit 0); timeout counter starts. First falling edge → BITS, drive data bit 0.
- BITS: on falling edges 2..8 drive data bits 1..7; edge 9 drives parity; edge 10 releases data (stop = 1). Bit value 0 → oe = 1, bit 1 → oe = 0. After edge 10 → ACK.
- ACK: on falling edge 11 sample synced data: 0 → ACK OK, 1 → NACK. → WAIT_IDLE.
- WAIT_IDLE: wait until synced clock and data both 1, then pulse `done` (ACK OK) or `error` (NACK) and return to IDLE.
- Timeout: counter reaching `TIMEOUT_CYCLES` in START/BITS/ACK releases both lines immediately, pulses `error`, → IDLE. Edge and timeout in the same cycle: timeout wins.
- `tx_valid` outside IDLE is ignored; `tx_data` changes after acceptance have no effect.
- Reset mid-frame: both lines released same cycle, state IDLE, no pulse.

## Timing
- Reset values: `tx_ready` = 1, `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `done` = 0, `error` = 0; synchronizers reset to 1.
- All outputs registered.
- Pad edge visible to FSM 3 cycles after pad change (2 sync + edge register); data oe updates on the cycle after the detected edge.
- `tx_ready` falls the cycle after acceptance.
- Acceptance to `ps2_clk_oe` high: 1 cycle; clock held exactly `INHIBIT_CYCLES` cycles.
- `done`/`error` never both high; each exactly one cycle.

## Configuration
- `PS2_TX_RETRY_EN` defined: on NACK or timeout the latched byte is re-sent once automatically (back to INHIBIT, no pulse); `error` only if the retry also fails; `done` if it succeeds. `tx_ready` stays low throughout.
- Undefined: first NACK/timeout pulses `error` and returns to IDLE.

## Test plan
- Send 0xED, device model clocks at 12.5 kHz and ACKs → clock held low 5000 cycles, data bits sampled by model 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses once, `tx_ready` returns to 1.
- Send 0x00 and 0xFF → parity bit 1 for both; send 0x01 → parity 0; `done` each time.
- Device NACKs (data high on edge 11) → `error` pulse, no `done`; with `PS2_TX_RETRY_EN`, second INHIBIT observed, retry ACKed → `done` only.
- Device never clocks → after 1000000 cycles in START both oe = 0, `error` pulses, `tx_ready` = 1.
- `reset` asserted after edge 5 → next cycle both oe = 0, `tx_ready` = 1, no pulse; next byte sends cleanly.
- `tx_valid` held high with new data during a frame → no second acceptance until IDLE; transmitted byte equals first latched value.
